// File: rtl/rpsc_interlock_seq_if.sv
// Signal bundle between the RF power-supply interlock sequencer and its controller.
// The controller side drives the alarm, status and operator inputs; the sequencer drives enables and status.
interface rpsc_interlock_seq_if;
    logic       i_Not_G1_Alarm;
    logic       i_Not_AN_Alarm;
    logic       i_Not_G1_ON_PERM;
    logic       i_Not_G1_OK;
    logic       i_Not_AN_OK;
    logic       i_Start;
    logic       i_Stop;
    logic       i_Ack;
    logic       o_G1_EN;
    logic       o_AN_EN;
    logic       o_Ready;
    logic       o_Fault;
    logic [2:0] o_Fault_Code;
    logic [2:0] o_State;

    modport master (
        output i_Not_G1_Alarm, i_Not_AN_Alarm, i_Not_G1_ON_PERM, i_Not_G1_OK,
               i_Not_AN_OK, i_Start, i_Stop, i_Ack,
        input  o_G1_EN, o_AN_EN, o_Ready, o_Fault, o_Fault_Code, o_State
    );

    modport slave (
        input  i_Not_G1_Alarm, i_Not_AN_Alarm, i_Not_G1_ON_PERM, i_Not_G1_OK,
               i_Not_AN_OK, i_Start, i_Stop, i_Ack,
        output o_G1_EN, o_AN_EN, o_Ready, o_Fault, o_Fault_Code, o_State
    );
endinterface

// File: rtl/rpsc_interlock_seq.sv
// Interlock sequencer: ramps the G1 supply then the anode supply, supervises both while running,
// and latches the first fault cause until the operator acknowledges with alarms clear.
module rpsc_interlock_seq #(
    parameter int G1_TIMEOUT = 256,
    parameter int AN_TIMEOUT = 512
) (
    input logic                 clk,
    input logic                 reset,
    rpsc_interlock_seq_if.slave bus
);

    localparam int CNT_LIMIT = (G1_TIMEOUT > AN_TIMEOUT) ? G1_TIMEOUT : AN_TIMEOUT;
    localparam int CW        = $clog2(CNT_LIMIT + 1);

    localparam logic [CW-1:0] CNT_SAT = '1;
    localparam logic [CW-1:0] G1_LAST = CW'(G1_TIMEOUT - 1);
    localparam logic [CW-1:0] AN_LAST = CW'(AN_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_G1_RAMP = 3'd1;
    localparam logic [2:0] ST_AN_RAMP = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_G1_ALARM   = 3'd1;
    localparam logic [2:0] FC_AN_ALARM   = 3'd2;
    localparam logic [2:0] FC_G1_TIMEOUT = 3'd3;
    localparam logic [2:0] FC_AN_TIMEOUT = 3'd4;
    localparam logic [2:0] FC_G1_LOST    = 3'd5;
    localparam logic [2:0] FC_AN_LOST    = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [2:0]    fault_code;
    logic [2:0]    code_nx;
    logic [2:0]    fault_sel;
    logic [CW-1:0] cnt;

    logic g1_alarm;
    logic an_alarm;
    logic alarms_clear;
    logic g1_not_ok;
    logic an_not_ok;

    assign g1_alarm     = !bus.i_Not_G1_Alarm;
    assign an_alarm     = !bus.i_Not_AN_Alarm;
    assign alarms_clear = !g1_alarm && !an_alarm;
    assign g1_not_ok    = bus.i_Not_G1_OK;
    assign an_not_ok    = bus.i_Not_AN_OK;

    // Fault cause for the active states, highest priority first; FC_NONE when healthy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fault_sel = FC_NONE;
        if (g1_alarm)
            fault_sel = FC_G1_ALARM;
        else if (an_alarm)
            fault_sel = FC_AN_ALARM;
        else if ((state == ST_AN_RAMP || state == ST_RUN) && g1_not_ok)
            fault_sel = FC_G1_LOST;
        else if (state == ST_RUN && an_not_ok)
            fault_sel = FC_AN_LOST;
        else if (state == ST_G1_RAMP && g1_not_ok && cnt == G1_LAST)
            fault_sel = FC_G1_TIMEOUT;
        else if (state == ST_AN_RAMP && an_not_ok && cnt == AN_LAST)
            fault_sel = FC_AN_TIMEOUT;
    end

    always_comb begin
        state_nx = state;
        code_nx  = fault_code;
        case (state)
            ST_IDLE: begin
                if (!bus.i_Stop && bus.i_Start && alarms_clear && !bus.i_Not_G1_ON_PERM)
                    state_nx = ST_G1_RAMP;
            end
            ST_G1_RAMP, ST_AN_RAMP, ST_RUN: begin
                if (fault_sel != FC_NONE) begin
                    state_nx = ST_FAULT;
                    code_nx  = fault_sel;
                end else if (bus.i_Stop) begin
                    state_nx = ST_IDLE;
                end else if (state == ST_G1_RAMP && !g1_not_ok) begin
                    state_nx = ST_AN_RAMP;
                end else if (state == ST_AN_RAMP && !an_not_ok) begin
                    state_nx = ST_RUN;
                end
            end
            ST_FAULT: begin
                // The code is held here untouched, so only the first fault is ever visible.
                if (bus.i_Ack && alarms_clear) begin
                    state_nx = ST_IDLE;
                    code_nx  = FC_NONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                code_nx  = FC_NONE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state            <= ST_IDLE;
            fault_code       <= FC_NONE;
            cnt              <= '0;
            bus.o_G1_EN      <= 1'b0;
            bus.o_AN_EN      <= 1'b0;
            bus.o_Ready      <= 1'b0;
            bus.o_Fault      <= 1'b0;
            bus.o_Fault_Code <= FC_NONE;
            bus.o_State      <= ST_IDLE;
        end else begin
            state      <= state_nx;
            fault_code <= code_nx;

            if (state_nx != state)
                cnt <= '0;
            else if ((state == ST_G1_RAMP || state == ST_AN_RAMP) && cnt != CNT_SAT)
                cnt <= cnt + CW'(1);

            bus.o_G1_EN      <= (state_nx == ST_G1_RAMP) || (state_nx == ST_AN_RAMP) ||
                                (state_nx == ST_RUN);
            bus.o_AN_EN      <= (state_nx == ST_AN_RAMP) || (state_nx == ST_RUN);
            bus.o_Ready      <= (state_nx == ST_RUN);
            bus.o_Fault      <= (state_nx == ST_FAULT);
            bus.o_Fault_Code <= code_nx;
            bus.o_State      <= state_nx;
        end
    end

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Scenario bench for the interlock sequencer: expected output vectors are queued as stimulus
// is driven and compared one edge later.
module tb_rpsc_interlock_seq;

    localparam int G1_T = 16;
    localparam int AN_T = 24;

    logic clk = 1'b0;
    logic reset;

    rpsc_interlock_seq_if bus ();

    rpsc_interlock_seq #(
        .G1_TIMEOUT(G1_T),
        .AN_TIMEOUT(AN_T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] vec;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    // Vector layout: {G1_EN, AN_EN, Ready, Fault, Fault_Code[2:0], State[2:0]}
    function automatic logic [9:0] obs();
        return {bus.o_G1_EN, bus.o_AN_EN, bus.o_Ready, bus.o_Fault, bus.o_Fault_Code, bus.o_State};
    endfunction

    function automatic logic [9:0] st_vec(input int s);
        case (s)
            0:       return 10'b0000_000_000;
            1:       return 10'b1000_000_001;
            2:       return 10'b1100_000_010;
            3:       return 10'b1110_000_011;
            default: return 10'bxxxx_xxx_xxx;
        endcase
    endfunction

    function automatic logic [9:0] fault_vec(input logic [2:0] code);
        return {4'b0001, code, 3'd4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Not_G1_Alarm   = 1'b1;
        bus.i_Not_AN_Alarm   = 1'b1;
        bus.i_Not_G1_ON_PERM = 1'b0;
        bus.i_Not_G1_OK      = 1'b1;
        bus.i_Not_AN_OK      = 1'b1;
        bus.i_Start          = 1'b0;
        bus.i_Stop           = 1'b0;
        bus.i_Ack            = 1'b0;
    endtask

    task automatic goto_run();
        bus.i_Not_G1_OK = 1'b0;
        bus.i_Not_AN_OK = 1'b0;
        bus.i_Start     = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        tick();
        tick();
    endtask

    task automatic recover();
        idle_inputs();
        bus.i_Ack = 1'b1;
        tick();
        bus.i_Ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        sb.push_back('{st_vec(0), "reset_state"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        reset = 1'b0;
    endtask

    task automatic test_start_gating();
        bus.i_Not_G1_ON_PERM = 1'b1;
        bus.i_Start          = 1'b1;
        sb.push_back('{st_vec(0), "start_without_perm"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        bus.i_Not_G1_ON_PERM = 1'b0;
        bus.i_Not_G1_Alarm   = 1'b0;
        sb.push_back('{st_vec(0), "start_with_g1_alarm"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        idle_inputs();
    endtask

    task automatic test_nominal();
        for (int c = 1; c <= 21; c++) begin
            bus.i_Start     = (c == 1);
            bus.i_Not_G1_OK = (c >= 10) ? 1'b0 : 1'b1;
            bus.i_Not_AN_OK = (c >= 20) ? 1'b0 : 1'b1;
            sb.push_back('{st_vec((c < 10) ? 1 : (c < 20) ? 2 : 3), $sformatf("nominal_c%0d", c)});
            tick();
            e = sb.pop_front();
            total++;
            if (obs() !== e.vec) begin
                bad++;
                $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
            end
        end
        bus.i_Stop = 1'b1;
        sb.push_back('{st_vec(0), "stop_from_run"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        idle_inputs();
    endtask

    task automatic test_g1_timeout();
        int  n    = 0;
        bit  seen = 1'b0;
        bus.i_Start = 1'b1;
        sb.push_back('{st_vec(1), "g1_ramp_entry"});
        sb.push_back('{fault_vec(3'd3), "g1_timeout_fault"});
        tick();
        bus.i_Start = 1'b0;
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        for (int k = 1; k <= G1_T + 4; k++) begin
            tick();
            if (bus.o_Fault === 1'b1) begin
                n    = k;
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || n != G1_T) begin
            bad++;
            $display("FAIL g1_timeout_latency got=%0d exp=%0d seen=%0b", n, G1_T, seen);
        end
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        recover();
    endtask

    task automatic test_an_timeout();
        int  n    = 0;
        bit  seen = 1'b0;
        bus.i_Start     = 1'b1;
        bus.i_Not_G1_OK = 1'b0;
        tick();
        bus.i_Start = 1'b0;
        sb.push_back('{st_vec(2), "an_ramp_entry"});
        sb.push_back('{fault_vec(3'd4), "an_timeout_fault"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        for (int k = 1; k <= AN_T + 4; k++) begin
            tick();
            if (bus.o_Fault === 1'b1) begin
                n    = k;
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || n != AN_T) begin
            bad++;
            $display("FAIL an_timeout_latency got=%0d exp=%0d seen=%0b", n, AN_T, seen);
        end
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        recover();
    endtask

    task automatic test_priority_and_ack();
        goto_run();
        bus.i_Not_G1_Alarm = 1'b0;
        bus.i_Not_AN_Alarm = 1'b0;
        bus.i_Stop         = 1'b1;
        sb.push_back('{fault_vec(3'd1), "prio_alarms_and_stop"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        bus.i_Stop      = 1'b0;
        bus.i_Not_G1_OK = 1'b1;
        sb.push_back('{fault_vec(3'd1), "code_frozen"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        bus.i_Not_G1_Alarm = 1'b1;
        bus.i_Ack          = 1'b1;
        sb.push_back('{fault_vec(3'd1), "ack_with_an_alarm"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        bus.i_Not_AN_Alarm = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{st_vec(0), $sformatf("ack_to_idle_%0d", k)});
            tick();
            e = sb.pop_front();
            total++;
            if (obs() !== e.vec) begin
                bad++;
                $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fault_codes();
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start        = 1'b0;
        bus.i_Not_AN_Alarm = 1'b0;
        sb.push_back('{fault_vec(3'd2), "an_alarm_in_g1_ramp"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        recover();

        goto_run();
        bus.i_Not_G1_OK = 1'b1;
        bus.i_Not_AN_OK = 1'b1;
        sb.push_back('{fault_vec(3'd5), "g1_lost_over_an_lost"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        recover();

        goto_run();
        bus.i_Not_AN_OK = 1'b1;
        bus.i_Stop      = 1'b1;
        sb.push_back('{fault_vec(3'd6), "an_lost_over_stop"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        recover();
    endtask

    task automatic test_reset_midop();
        bus.i_Start     = 1'b1;
        bus.i_Not_G1_OK = 1'b0;
        tick();
        bus.i_Start = 1'b0;
        sb.push_back('{st_vec(2), "midop_an_ramp"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        reset = 1'b1;
        sb.push_back('{st_vec(0), "midop_reset"});
        tick();
        e = sb.pop_front();
        total++;
        if (obs() !== e.vec) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
        end
        reset = 1'b0;
        idle_inputs();
        bus.i_Start = 1'b1;
        bus.i_Stop  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{st_vec(0), $sformatf("start_and_stop_%0d", k)});
            tick();
            e = sb.pop_front();
            total++;
            if (obs() !== e.vec) begin
                bad++;
                $display("FAIL %s got=%b exp=%b", e.name, obs(), e.vec);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_start_gating();
        test_nominal();
        test_g1_timeout();
        test_an_timeout();
        test_priority_and_ack();
        test_fault_codes();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
